// File: rtl/kong_animator_pkg.sv
// rtl/kong_animator_pkg.sv - shared Kong state codes and sprite geometry
package kong_animator_pkg;

  typedef enum logic [1:0] {
    KONG_NORMAL = 2'd0,
    KONG_GET    = 2'd1,
    KONG_HOLD   = 2'd2,
    KONG_DROP   = 2'd3
  } kong_state_t;

  localparam int unsigned KONG_SPRITE_W = 112;
  localparam int unsigned KONG_SPRITE_H = 72;

endpackage

// File: rtl/kong_animator.sv
// rtl/kong_animator.sv - frame-rate throw-cycle sequencer for the Kong sprite
import kong_animator_pkg::*;

module kong_animator #(
  parameter int unsigned NORMAL_FRAMES = 90,
  parameter int unsigned GET_FRAMES    = 20,
  parameter int unsigned HOLD_FRAMES   = 20,
  parameter int unsigned DROP_FRAMES   = 15,
  parameter logic [9:0]  KONG_X        = 10'd40,
  parameter logic [8:0]  KONG_Y        = 9'd56
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       pause,
  input  logic       slot_free,
  output logic [3:0] animate_state,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       barrel_spawn,
  output logic       throwing
);

  kong_state_t r_state;
  kong_state_t w_state_nxt;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_last;
  logic        r_spawn;
  logic        w_spawn_nxt;
  logic        r_throwing;

  always_comb begin
    w_last = 8'(NORMAL_FRAMES - 1);
    case (r_state)
      KONG_NORMAL: w_last = 8'(NORMAL_FRAMES - 1);
      KONG_GET:    w_last = 8'(GET_FRAMES - 1);
      KONG_HOLD:   w_last = 8'(HOLD_FRAMES - 1);
      KONG_DROP:   w_last = 8'(DROP_FRAMES - 1);
      default:     w_last = 8'(NORMAL_FRAMES - 1);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    w_spawn_nxt = 1'b0;
    if (!run) begin
      w_state_nxt = KONG_NORMAL;
      w_cnt_nxt   = 8'd0;
    end else if (pause) begin
      w_state_nxt = r_state;
    end else if (frame_tick) begin
      if (r_frame_cnt == w_last) begin
        w_cnt_nxt = 8'd0;
        case (r_state)
          KONG_NORMAL: w_state_nxt = KONG_GET;
          KONG_GET:    w_state_nxt = KONG_HOLD;
          KONG_HOLD: begin
            // No free slot: stall at the last HOLD frame and retest on every later tick
            if (slot_free) begin
              w_state_nxt = KONG_DROP;
              w_spawn_nxt = 1'b1;
            end else begin
              w_cnt_nxt = r_frame_cnt;
            end
          end
          KONG_DROP:   w_state_nxt = KONG_NORMAL;
          default:     w_state_nxt = KONG_NORMAL;
        endcase
      end else begin
        w_cnt_nxt = r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= KONG_NORMAL;
      r_frame_cnt <= 8'd0;
      r_spawn     <= 1'b0;
      r_throwing  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_spawn     <= w_spawn_nxt;
      r_throwing  <= (w_state_nxt != KONG_NORMAL);
    end
  end

  assign animate_state = {2'b00, r_state};
  assign barrel_spawn  = r_spawn;
  assign throwing      = r_throwing;
  assign posx          = KONG_X;
  assign posy          = KONG_Y;

endmodule

// File: tb/tb_kong_animator.sv
// tb/tb_kong_animator.sv - self-checking bench: default and all-ones frame lengths
module tb_kong_animator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       run = 1'b0;
  logic       pause = 1'b0;
  logic       slot_free = 1'b1;
  logic [3:0] as0, as1;
  logic [9:0] px0, px1;
  logic [8:0] py0, py1;
  logic       sp0, sp1, th0, th1;

  always #5 clk = ~clk;

  kong_animator dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .pause(pause),
    .slot_free(slot_free), .animate_state(as0), .posx(px0), .posy(py0),
    .barrel_spawn(sp0), .throwing(th0)
  );

  kong_animator #(
    .NORMAL_FRAMES(1), .GET_FRAMES(1), .HOLD_FRAMES(1), .DROP_FRAMES(1)
  ) dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .pause(pause),
    .slot_free(slot_free), .animate_state(as1), .posx(px1), .posy(py1),
    .barrel_spawn(sp1), .throwing(th1)
  );

  int checks = 0;
  int errors = 0;
  int lens [2][4] = '{'{90, 20, 20, 15}, '{1, 1, 1, 1}};
  int ms [2];
  int me [2];
  int msp [2];
  int spawns0 = 0;
  int spawns1 = 0;
  int s0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: frames elapsed in the current pose; a pose ends once it has lasted its length
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      msp[i] = 0;
      if (rst || !run) begin
        ms[i] = 0;
        me[i] = 0;
      end else if (!pause && frame_tick) begin
        me[i] = me[i] + 1;
        if (me[i] >= lens[i][ms[i]]) begin
          if (ms[i] == 2 && !slot_free) begin
            me[i] = lens[i][2];
          end else begin
            if (ms[i] == 2) msp[i] = 1;
            ms[i] = (ms[i] + 1) % 4;
            me[i] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("state0", int'(as0), ms[0]);
    check("spawn0", int'(sp0), msp[0]);
    check("throw0", int'(th0), int'(ms[0] != 0));
    check("state1", int'(as1), ms[1]);
    check("spawn1", int'(sp1), msp[1]);
    check("throw1", int'(th1), int'(ms[1] != 0));
    check("posx0", int'(px0), 40);
    check("posy0", int'(py0), 56);
    check("posx1", int'(px1), 40);
    check("posy1", int'(py1), 56);
    if (sp0) spawns0++;
    if (sp1) spawns1++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
    end
  endtask

  initial begin
    #12;
    check("rst_state", int'(as0), 0);
    check("rst_spawn", int'(sp0), 0);
    check("rst_throw", int'(th0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run = 1'b1;
    slot_free = 1'b1;

    tick(1); check("short_t1", int'(as1), 1);
    tick(1); check("short_t2", int'(as1), 2);
    tick(1); check("short_t3", int'(as1), 3); check("short_sp_t3", int'(sp1), 1);
    tick(1); check("short_t4", int'(as1), 0); check("short_spawns4", spawns1, 1);

    tick(86);  check("nom_t90", int'(as0), 1);
    tick(19);  check("nom_t109", int'(as0), 1);
    tick(1);   check("nom_t110", int'(as0), 2);
    tick(19);  check("nom_t129", int'(as0), 2); check("nom_nospawn", spawns0, 0);
    tick(1);   check("nom_t130", int'(as0), 3); check("nom_sp", int'(sp0), 1);
    tick(14);  check("nom_t144", int'(as0), 3); check("nom_spawns", spawns0, 1);
    tick(1);   check("nom_t145", int'(as0), 0); check("nom_throw", int'(th0), 0);
    check("short_spawns145", spawns1, 36);

    slot_free = 1'b0;
    s0 = spawns0;
    tick(130); check("stall_t130", int'(as0), 2);
    tick(6);   check("stall_t136", int'(as0), 2); check("stall_nospawn", spawns0, s0);
    slot_free = 1'b1;
    tick(1);   check("stall_t137", int'(as0), 3); check("stall_sp", int'(sp0), 1);
    tick(14);  check("stall_t151", int'(as0), 3);
    tick(1);   check("stall_t152", int'(as0), 0); check("stall_spawns", spawns0, s0 + 1);

    tick(40);
    pause = 1'b1;
    tick(50);  check("pause_frozen", int'(as0), 0);
    pause = 1'b0;
    tick(49);  check("pause_t139", int'(as0), 0);
    tick(1);   check("pause_t140", int'(as0), 1);
    tick(55);  check("pause_cycle_end", int'(as0), 0);

    tick(129); check("rundrop_hold", int'(as0), 2);
    s0 = spawns0;
    @(posedge clk);
    #1 frame_tick = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    check("rundrop_state", int'(as0), 0);
    check("rundrop_sp", int'(sp0), 0);
    check("rundrop_throw", int'(th0), 0);
    @(posedge clk);
    #1 check("rundrop_nospawn", spawns0, s0);
    run = 1'b1;
    tick(89);  check("rerun_t89", int'(as0), 0);
    tick(1);   check("rerun_t90", int'(as0), 1);

    tick(5);   check("midget_pre", int'(as0), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(as0), 0);
    check("arst_spawn", int'(sp0), 0);
    check("arst_throw", int'(th0), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(90);  check("post_rst_t90", int'(as0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
